matrix_scan_ctrl: RTL and testbench

MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

---
 rtl/matrix_scan_ctrl_pkg.sv | 19 +
 rtl/matrix_scan_ctrl_bcm_timer.sv | 25 ++
 rtl/matrix_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/matrix_scan_ctrl_pkg.sv
// matrix_scan_ctrl_pkg: shared scan states, parameter defaults and width helper
package matrix_scan_ctrl_pkg;
  localparam int COLS_DEF = 32;
  localparam int ROW_BITS_DEF = 4;
  localparam int PLANES_DEF = 4;
  localparam int BASE_TICKS_DEF = 64;
  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    CLOCK,
    BLANK,
    LATCH,
    DISPLAY
  } scan_state_e;
  function automatic int tick_width(input int row_bits, input int planes);
    return row_bits + planes + 6;
  endfunction
endpackage

// File: rtl/matrix_scan_ctrl_bcm_timer.sv
// bcm_timer: display-period down-counter, loads BASE_TICKS<<plane and flags the last tick
module bcm_timer
  import matrix_scan_ctrl_pkg::*;
#(
  parameter int BASE_TICKS = BASE_TICKS_DEF,
  parameter int TICK_W = tick_width(ROW_BITS_DEF, PLANES_DEF),
  parameter int PL_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            run_i,
  input  logic [PL_W-1:0] plane_i,
  output logic            done_o
);
  logic [TICK_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? TICK_W'(BASE_TICKS) << plane_i
                    : (run_i && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  // the cycle holding count 1 is the final lit cycle, so the period is exactly the loaded value
  assign done_o = run_i && cnt_q == TICK_W'(1);
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: HUB75-style BCM panel scanner reading pixel pairs from an external framebuffer
module matrix_scan_ctrl
  import matrix_scan_ctrl_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROW_BITS = ROW_BITS_DEF,
  parameter int PLANES = PLANES_DEF,
  parameter int BASE_TICKS = BASE_TICKS_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  output logic [ROW_BITS+$clog2(COLS)-1:0]  rd_addr,
  input  logic [6*PLANES-1:0]               rd_data,
  output logic                              R0,
  output logic                              G0,
  output logic                              B0,
  output logic                              R1,
  output logic                              G1,
  output logic                              B1,
  output logic                              A,
  output logic                              B,
  output logic                              C,
  output logic                              D,
  output logic                              MATCLK,
  output logic                              MATLAT,
  output logic                              MATOE,
  output logic                              frame_done
);
  localparam int COL_W = $clog2(COLS);
  localparam int AW = ROW_BITS + COL_W;
  localparam int PL_W = PLANES > 1 ? $clog2(PLANES) : 1;
  localparam int TICK_W = tick_width(ROW_BITS, PLANES);
  scan_state_e state_q, state_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [PL_W-1:0] plane_q, plane_d;
  logic [COL_W-1:0] col_q, col_d;
  logic en_q, tick_done, last_col, last_plane, last_row;
  logic [AW-1:0] addr_q, addr_d;
  logic [5:0] rgb_q, rgb_d;
  logic [3:0] abcd_q, abcd_d;
  logic mclk_q, mclk_d, mlat_q, mlat_d, moe_q, moe_d, fdone_q, fdone_d;
  logic [5:0][PLANES-1:0] chan;
  assign chan = rd_data;
  assign last_col = col_q == COL_W'(COLS - 1);
  assign last_plane = plane_q == PL_W'(PLANES - 1);
  assign last_row = &row_q;
  bcm_timer #(
    .BASE_TICKS(BASE_TICKS),
    .TICK_W(TICK_W),
    .PL_W(PL_W)
  ) u_bcm_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load_i(state_q == LATCH),
    .run_i(state_q == DISPLAY),
    .plane_i(plane_q),
    .done_o(tick_done)
  );
  // enable is registered first, so a start from reset needs two enabled edges
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q <= '0;
      plane_q <= '0;
      col_q <= '0;
      en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      plane_q <= plane_d;
      col_q <= col_d;
      en_q <= enable;
    end
  end
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    plane_d = plane_q;
    col_d = col_q;
    case (state_q)
      IDLE: begin
        state_d = en_q ? FETCH : IDLE;
        col_d = '0;
      end
      FETCH: state_d = LOAD;
      LOAD: state_d = CLOCK;
      CLOCK: begin
        state_d = last_col ? BLANK : FETCH;
        col_d = last_col ? '0 : col_q + 1'b1;
      end
      BLANK: state_d = LATCH;
      LATCH: state_d = DISPLAY;
      DISPLAY: if (tick_done) begin
        state_d = en_q ? FETCH : IDLE;
        plane_d = last_plane ? '0 : plane_q + 1'b1;
        row_d = last_plane ? row_q + 1'b1 : row_q;
        col_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // outputs are decoded from the next state so every pin comes straight from a flop
  always_comb begin
    moe_d = state_d != DISPLAY;
    mclk_d = state_d == CLOCK;
    mlat_d = state_d == LATCH;
    addr_d = state_d == FETCH ? {row_d, col_d} : addr_q;
    abcd_d = state_d == BLANK ? 4'(row_q) : abcd_q;
    fdone_d = state_q == DISPLAY && tick_done && last_row && last_plane;
    rgb_d = rgb_q;
    for (int j = 0; j < 6; j++) rgb_d[j] = state_q == LOAD ? chan[j][plane_q] : rgb_q[j];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      rgb_q <= '0;
      abcd_q <= '0;
      mclk_q <= 1'b0;
      mlat_q <= 1'b0;
      moe_q <= 1'b1;
      fdone_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      rgb_q <= rgb_d;
      abcd_q <= abcd_d;
      mclk_q <= mclk_d;
      mlat_q <= mlat_d;
      moe_q <= moe_d;
      fdone_q <= fdone_d;
    end
  end
  assign rd_addr = addr_q;
  assign {R0, G0, B0, R1, G1, B1} = rgb_q;
  assign {D, C, B, A} = abcd_q;
  assign MATCLK = mclk_q;
  assign MATLAT = mlat_q;
  assign MATOE = moe_q;
  assign frame_done = fdone_q;
endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb_matrix_scan_ctrl: scoreboard bench for shift data, row latching, BCM periods, enable and reset
module tb_matrix_scan_ctrl;
  localparam int COLS = 32;
  localparam int ROW_BITS = 4;
  localparam int PLANES = 4;
  localparam int BASE = 64;
  localparam int COL_W = 5;
  localparam int AW = ROW_BITS + COL_W;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic [AW-1:0] rd_addr;
  logic [6*PLANES-1:0] rd_data = '0;
  logic R0, G0, B0, R1, G1, B1, A, B, C, D, MATCLK, MATLAT, MATOE, frame_done;
  int compared = 0;
  int mismatched = 0;
  logic [5:0] sh_q[$];
  int lat_q[$];
  int disp_q[$];
  int cyc = 0, first_mclk = -1, fd_cyc = -1, n_fd = 0, n_mclk = 0, n_lat = 0, n_disp = 0;
  int edges_rp = 0, oe_run = 0, disp_row = 0;
  logic prev_mclk = 1'b0;

  matrix_scan_ctrl #(
    .COLS(COLS),
    .ROW_BITS(ROW_BITS),
    .PLANES(PLANES),
    .BASE_TICKS(BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rd_addr(rd_addr), .rd_data(rd_data),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .A(A), .B(B), .C(C), .D(D),
    .MATCLK(MATCLK), .MATLAT(MATLAT), .MATOE(MATOE), .frame_done(frame_done)
  );

  always #10 clk = ~clk;

  function automatic logic [23:0] fb(input int r, input int c);
    logic [23:0] alt, mix;
    alt = c[0] ? 24'hFFFFFF : 24'h000000;
    mix = 24'((r * COLS + c) * 32'h002C1B37);
    return r == 0 ? alt : alt ^ mix;
  endfunction

  function automatic logic [5:0] bits(input logic [23:0] w, input int p);
    logic [5:0] b;
    for (int j = 0; j < 6; j++) b[j] = w[j*PLANES+p];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic exp_rp(input int r, input int p);
    for (int c = 0; c < COLS; c++) sh_q.push_back(bits(fb(r, c), p));
    lat_q.push_back(r);
    disp_q.push_back(BASE << p);
  endtask

  always @(posedge clk) rd_data <= fb(int'(rd_addr[AW-1:COL_W]), int'(rd_addr[COL_W-1:0]));

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      oe_run = 0;
      edges_rp = 0;
      prev_mclk = 1'b0;
    end else begin
      if (MATCLK && !prev_mclk) begin
        n_mclk++;
        edges_rp++;
        if (first_mclk < 0) first_mclk = cyc;
        chk("shift_avail", sh_q.size() > 0, 1);
        if (sh_q.size() > 0) chk("shift_data", {R0, G0, B0, R1, G1, B1}, sh_q.pop_front());
      end
      if (MATLAT) begin
        n_lat++;
        chk("latch_oe", MATOE, 1);
        chk("latch_edges", edges_rp, COLS);
        chk("latch_avail", lat_q.size() > 0, 1);
        if (lat_q.size() > 0) begin
          disp_row = lat_q.pop_front();
          chk("row_addr", {D, C, B, A}, disp_row);
        end
        edges_rp = 0;
      end
      if (!MATOE) begin
        oe_run++;
        chk("addr_stable", {D, C, B, A}, disp_row);
      end else if (oe_run > 0) begin
        n_disp++;
        chk("disp_avail", disp_q.size() > 0, 1);
        if (disp_q.size() > 0) chk("disp_len", oe_run, disp_q.pop_front());
        oe_run = 0;
      end
      if (frame_done) begin
        n_fd++;
        if (fd_cyc < 0) fd_cyc = cyc;
      end
      prev_mclk = MATCLK;
    end
  end

  initial begin
    int m, base;
    enable = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_oe", MATOE, 1);
    chk("reset_outs", {MATCLK, MATLAT, R0, G0, B0, R1, G1, B1, A, B, C, D, frame_done}, 0);
    chk("reset_addr", rd_addr, 0);
    for (int r = 0; r < 16; r++) for (int p = 0; p < PLANES; p++) exp_rp(r, p);
    for (int k = 0; k <= 22; k++) exp_rp(k / 4, k % 4);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("no_early_fetch", MATCLK, 0);
    end
    for (int i = 0; i < 30000 && fd_cyc < 0; i++) @(negedge clk);
    chk("frame_done_seen", fd_cyc >= 0, 1);
    chk("frame_done_time", fd_cyc - first_mclk, 21630);
    @(negedge clk);
    chk("frame_done_width", frame_done, 0);
    chk("frame_done_count", n_fd, 1);
    chk("frame_latches", n_lat, 64);
    for (int i = 0; i < 20000 && n_lat < 86; i++) @(negedge clk);
    chk("reach_r5p2", n_lat, 86);
    for (int i = 0; i < 2000 && edges_rp < 10; i++) @(negedge clk);
    chk("mid_shift", edges_rp >= 10, 1);
    enable = 1'b0;
    for (int i = 0; i < 2000 && n_disp < 87; i++) @(negedge clk);
    chk("rowplane_done", n_disp, 87);
    m = n_mclk;
    repeat (20) begin
      @(negedge clk);
      chk("idle_blank", MATOE, 1);
    end
    chk("idle_no_clk", n_mclk, m);
    chk("idle_drained", sh_q.size() + lat_q.size() + disp_q.size(), 0);
    exp_rp(5, 3);
    enable = 1'b1;
    for (int i = 0; i < 500 && MATOE !== 1'b0; i++) @(negedge clk);
    chk("resume_display", MATOE, 0);
    chk("resume_latches", n_lat, 88);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_oe", MATOE, 1);
    chk("midrst_outs", {MATCLK, MATLAT, R0, G0, B0, R1, G1, B1, A, B, C, D, frame_done}, 0);
    chk("midrst_addr", rd_addr, 0);
    sh_q.delete();
    lat_q.delete();
    disp_q.delete();
    @(negedge clk);
    exp_rp(0, 0);
    exp_rp(0, 1);
    base = n_disp;
    rst_n = 1'b1;
    for (int i = 0; i < 2000 && n_disp < base + 2; i++) @(negedge clk);
    chk("restart_displays", n_disp - base, 2);
    chk("restart_drained", sh_q.size() + lat_q.size() + disp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
